// File: rtl/alu_seq_if.sv
// Request/result bundle for alu_seq. The master drives operands and the
// opcode; the slave (the ALU) returns ready, the registered result and flags.
interface alu_seq_if #(
  parameter int OPER_WIDTH = 8,
  parameter int OUT_WIDTH  = 2*OPER_WIDTH
);
  logic [OPER_WIDTH-1:0] i_a;
  logic [OPER_WIDTH-1:0] i_b;
  logic [3:0]            i_fun;
  logic                  i_signed;
  logic                  i_valid;
  logic                  o_ready;
  logic [OUT_WIDTH-1:0]  o_alu_out;
  logic [3:0]            o_flags;
  logic                  o_out_valid;

  modport master (
    output i_a, i_b, i_fun, i_signed, i_valid,
    input  o_ready, o_alu_out, o_flags, o_out_valid
  );

  modport slave (
    input  i_a, i_b, i_fun, i_signed, i_valid,
    output o_ready, o_alu_out, o_flags, o_out_valid
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential execute-stage ALU. Single-cycle ops (logic, add/sub, compare,
// shift) register their result at the accept edge; MUL and DIV iterate one
// bit per clock for OPER_WIDTH clocks while o_ready is held low.
// Flags: [0] Z, [1] C/borrow, [2] V, [3] DZ.
module alu_seq #(
  parameter int OPER_WIDTH = 8,
  parameter int OUT_WIDTH  = 2*OPER_WIDTH
) (
  input  logic    i_clk,
  input  logic    i_rst,
  alu_seq_if.slave bus
);
  localparam int W   = OPER_WIDTH;
  localparam int CW  = $clog2(W);
  localparam int PAD = OUT_WIDTH - W;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_NAND = 4'd6;
  localparam logic [3:0] OP_NOR  = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_XNOR = 4'd9;
  localparam logic [3:0] OP_EQL  = 4'd10;
  localparam logic [3:0] OP_GRT  = 4'd11;
  localparam logic [3:0] OP_LESS = 4'd12;
  localparam logic [3:0] OP_SHR  = 4'd13;
  localparam logic [3:0] OP_SHL  = 4'd14;

  typedef enum logic {IDLE, BUSY} state_t;

  // Context kept for the iterative ops; operands on the bus are free to
  // change once the op has been accepted.
  typedef struct packed {
    logic         is_div;
    logic [W-1:0] dvsr;
  } ctx_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt;
  ctx_t           ctx;

  logic [W-1:0]   a, b;
  logic           accept, iter_op, last;

  // Shift-add multiplier state
  logic [OUT_WIDTH-1:0] mcand, acc, acc_nx;
  logic [W-1:0]         mplier;

  // Restoring divider state: quo starts as the dividend and is shifted out
  // into rem while quotient bits are shifted in from the bottom.
  logic [W-1:0]   rem, quo, rem_nx, quo_nx;
  logic [W:0]     rem_sh;
  logic [W+1:0]   trial;

  // Single-cycle datapath
  logic [W:0]           sum;
  logic [OUT_WIDTH-1:0] a_ext, b_ext, a_sx, diff, res1;
  logic [W-1:0]         lg;
  logic [CW-1:0]        sh;
  logic                 c1, v1;

  logic [OUT_WIDTH-1:0] iter_res;

  assign a       = bus.i_a;
  assign b       = bus.i_b;
  assign accept  = bus.i_valid && bus.o_ready;
  assign iter_op = (bus.i_fun == OP_MUL) || (bus.i_fun == OP_DIV);
  assign last    = (state == BUSY) && (cnt == CW'(W-1));
  assign bus.o_ready = (state == IDLE);

  assign a_ext = {{PAD{1'b0}}, a};
  assign b_ext = {{PAD{1'b0}}, b};
  assign a_sx  = {{PAD{a[W-1]}}, a};
  // Shift amount is b mod W; W is a power of two so the low bits suffice.
  assign sh    = b[CW-1:0];

  // State register and iteration counter
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state == BUSY && state_nx == BUSY) ? cnt + CW'(1) : '0;
    end
  end

  // Next-state: MUL/DIV park in BUSY for W edges, everything else stays IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && iter_op) state_nx = BUSY;
      BUSY:    if (last)              state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One iteration of multiply and divide, plus the final iterative result
  always_comb begin
    acc_nx = mplier[0] ? (acc + mcand) : acc;
    rem_sh = {rem, quo[W-1]};
    trial  = {1'b0, rem_sh} - {2'b00, ctx.dvsr};
    // A zero divisor never goes negative, so the quotient fills with ones and
    // the dividend drains into the remainder on its own.
    if (!trial[W+1]) begin
      rem_nx = trial[W-1:0];
      quo_nx = {quo[W-2:0], 1'b1};
    end else begin
      rem_nx = rem_sh[W-1:0];
      quo_nx = {quo[W-2:0], 1'b0};
    end
    iter_res = ctx.is_div ? OUT_WIDTH'({rem_nx, quo_nx}) : acc_nx;
  end

  // Single-cycle results and their C/V flags
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = a_ext - b_ext;
    lg   = '0;
    res1 = '0;
    c1   = 1'b0;
    v1   = 1'b0;
    case (bus.i_fun)
      OP_ADD: begin
        res1 = {{(PAD-1){1'b0}}, sum};
        c1   = sum[W];
        v1   = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_SUB: begin
        res1 = diff;
        c1   = (a < b);
        v1   = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      OP_AND:  begin lg = a & b;    res1 = {{PAD{1'b0}}, lg}; end
      OP_OR:   begin lg = a | b;    res1 = {{PAD{1'b0}}, lg}; end
      OP_NAND: begin lg = ~(a & b); res1 = {{PAD{1'b0}}, lg}; end
      OP_NOR:  begin lg = ~(a | b); res1 = {{PAD{1'b0}}, lg}; end
      OP_XOR:  begin lg = a ^ b;    res1 = {{PAD{1'b0}}, lg}; end
      OP_XNOR: begin lg = ~(a ^ b); res1 = {{PAD{1'b0}}, lg}; end
      OP_EQL:  res1 = (a == b) ? OUT_WIDTH'(1) : '0;
      OP_GRT: begin
        if (bus.i_signed) res1 = ($signed(a) > $signed(b)) ? OUT_WIDTH'(2) : '0;
        else              res1 = (a > b)                   ? OUT_WIDTH'(2) : '0;
      end
      OP_LESS: begin
        if (bus.i_signed) res1 = ($signed(a) < $signed(b)) ? OUT_WIDTH'(3) : '0;
        else              res1 = (a < b)                   ? OUT_WIDTH'(3) : '0;
      end
      OP_SHR: begin
        if (bus.i_signed) res1 = $signed(a_sx) >>> sh;
        else              res1 = a_ext >> sh;
      end
      OP_SHL:  res1 = a_ext << sh;
      default: res1 = '0;
    endcase
  end

  // Datapath registers: capture at accept, iterate while BUSY, publish results
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      bus.o_alu_out   <= '0;
      bus.o_flags     <= '0;
      bus.o_out_valid <= 1'b0;
      ctx             <= '0;
      mcand           <= '0;
      mplier          <= '0;
      acc             <= '0;
      rem             <= '0;
      quo             <= '0;
    end else begin
      bus.o_out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (iter_op) begin
              ctx.is_div <= (bus.i_fun == OP_DIV);
              ctx.dvsr   <= b;
              mcand      <= a_ext;
              mplier     <= b;
              acc        <= '0;
              rem        <= '0;
              quo        <= a;
            end else begin
              bus.o_alu_out   <= res1;
              bus.o_flags     <= {1'b0, v1, c1, (res1 == '0)};
              bus.o_out_valid <= 1'b1;
            end
          end
        end
        BUSY: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          rem    <= rem_nx;
          quo    <= quo_nx;
          if (last) begin
            bus.o_alu_out   <= iter_res;
            bus.o_flags     <= {(ctx.is_div && ctx.dvsr == '0), 2'b00, (iter_res == '0)};
            bus.o_out_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus randomized ops
// compared against an arithmetic reference model.
module tb_alu_seq;
  localparam int W  = 8;
  localparam int OW = 2*W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.OPER_WIDTH(W)) bus();

  alu_seq #(.OPER_WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  // Reference model: plain integer arithmetic on the opcode definitions
  function automatic void model(input int a, input int b, input int fun, input bit sgn,
                                output int res, output int flg);
    int sa, sb, t, sh, mask, omask;
    bit c, v, dz;
    mask  = (1 << W) - 1;
    omask = (1 << OW) - 1;
    sa = (a >= (1 << (W-1))) ? a - (1 << W) : a;
    sb = (b >= (1 << (W-1))) ? b - (1 << W) : b;
    sh = b % W;
    c = 0; v = 0; dz = 0; res = 0;
    case (fun)
      0:  begin res = a + b; c = (res > mask); t = sa + sb;
                v = (t >= (1 << (W-1))) || (t < -(1 << (W-1))); end
      1:  begin res = (a - b) & omask; c = (a < b); t = sa - sb;
                v = (t >= (1 << (W-1))) || (t < -(1 << (W-1))); end
      2:  res = a * b;
      3:  if (b == 0) begin res = (a << W) | mask; dz = 1; end
          else res = ((a % b) << W) | (a / b);
      4:  res = a & b;
      5:  res = a | b;
      6:  res = ~(a & b) & mask;
      7:  res = ~(a | b) & mask;
      8:  res = a ^ b;
      9:  res = ~(a ^ b) & mask;
      10: res = (a == b) ? 1 : 0;
      11: res = (sgn ? (sa > sb) : (a > b)) ? 2 : 0;
      12: res = (sgn ? (sa < sb) : (a < b)) ? 3 : 0;
      13: res = sgn ? ((sa >>> sh) & omask) : (a >> sh);
      14: res = (a << sh) & omask;
      default: res = 0;
    endcase
    flg = (int'(dz) << 3) | (int'(v) << 2) | (int'(c) << 1) | ((res == 0) ? 1 : 0);
  endfunction

  // Drive one request for a single cycle and wait (bounded) for its result.
  // lat counts falling edges from the accept edge to the first visible pulse.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] fun,
                       input bit sgn, output logic [OW-1:0] r, output logic [3:0] f,
                       output int lat);
    @(negedge clk);
    bus.i_a = a; bus.i_b = b; bus.i_fun = fun; bus.i_signed = sgn; bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    lat = 1;
    while (bus.o_out_valid !== 1'b1 && lat < 4*W) begin
      @(negedge clk);
      lat++;
    end
    r = bus.o_alu_out;
    f = bus.o_flags;
  endtask

  task automatic test_reset();
    bus.i_a = '0; bus.i_b = '0; bus.i_fun = '0; bus.i_signed = 1'b0; bus.i_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.o_alu_out !== '0 || bus.o_flags !== 4'h0 || bus.o_out_valid !== 1'b0 ||
        bus.o_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state out=%h flags=%h vld=%b rdy=%b required 0/0/0/1",
               bus.o_alu_out, bus.o_flags, bus.o_out_valid, bus.o_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    logic [OW-1:0] r; logic [3:0] f; int lat;
    do_op(8'd200, 8'd100, 4'd0, 1'b0, r, f, lat);
    checks++;
    if (r !== 16'h012C || f !== 4'b0010 || lat !== 1) begin
      failures++;
      $display("FAIL add_200_100 out=%h flags=%b lat=%0d required 012c/0010/1", r, f, lat);
    end
    @(negedge clk);
    checks++;
    if (bus.o_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_single_pulse vld=%b required 0", bus.o_out_valid);
    end
  endtask

  task automatic test_div_hold();
    int busy = 0;
    int n = 0;
    @(negedge clk);
    bus.i_a = 8'd200; bus.i_b = 8'd7; bus.i_fun = 4'd3; bus.i_signed = 1'b0; bus.i_valid = 1'b1;
    @(negedge clk);
    while (bus.o_out_valid !== 1'b1 && n < 4*W) begin
      if (bus.o_ready === 1'b0) busy++;
      @(negedge clk);
      n++;
    end
    bus.i_valid = 1'b0;
    checks++;
    if (busy !== W || bus.o_ready !== 1'b1) begin
      failures++;
      $display("FAIL div_ready_low cycles=%0d rdy_at_result=%b required %0d/1",
               busy, bus.o_ready, W);
    end
    checks++;
    if (bus.o_alu_out !== 16'h041C || bus.o_flags !== 4'h0) begin
      failures++;
      $display("FAIL div_200_7 out=%h flags=%b required 041c/0000", bus.o_alu_out, bus.o_flags);
    end
    @(negedge clk);
    checks++;
    if (bus.o_out_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
      failures++;
      $display("FAIL div_held_valid_not_reaccepted vld=%b rdy=%b required 0/1",
               bus.o_out_valid, bus.o_ready);
    end
  endtask

  task automatic test_div_zero();
    logic [OW-1:0] r; logic [3:0] f; int lat;
    do_op(8'h55, 8'h00, 4'd3, 1'b0, r, f, lat);
    checks++;
    if (r !== 16'h55FF || f !== 4'b1000 || lat !== W+1) begin
      failures++;
      $display("FAIL div_by_zero out=%h flags=%b lat=%0d required 55ff/1000/%0d", r, f, lat, W+1);
    end
  endtask

  task automatic test_mul_toggle();
    int n = 1;
    @(negedge clk);
    bus.i_a = 8'hFF; bus.i_b = 8'hFF; bus.i_fun = 4'd2; bus.i_signed = 1'b0; bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    while (bus.o_out_valid !== 1'b1 && n < 4*W) begin
      bus.i_a = 8'($urandom); bus.i_b = 8'($urandom);
      bus.i_fun = 4'($urandom); bus.i_signed = 1'($urandom);
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.o_alu_out !== 16'hFE01 || bus.o_flags !== 4'h0 || n !== W+1) begin
      failures++;
      $display("FAIL mul_toggle out=%h flags=%b lat=%0d required fe01/0000/%0d",
               bus.o_alu_out, bus.o_flags, n, W+1);
    end
  endtask

  task automatic test_compare_shift();
    logic [OW-1:0] r; logic [3:0] f; int lat;
    do_op(8'h80, 8'h01, 4'd11, 1'b0, r, f, lat);
    checks++;
    if (r !== 16'd2 || f !== 4'b0000) begin
      failures++;
      $display("FAIL grt_unsigned out=%h flags=%b required 0002/0000", r, f);
    end
    do_op(8'h80, 8'h01, 4'd11, 1'b1, r, f, lat);
    checks++;
    if (r !== 16'd0 || f !== 4'b0001) begin
      failures++;
      $display("FAIL grt_signed out=%h flags=%b required 0000/0001", r, f);
    end
    do_op(8'h90, 8'd3, 4'd13, 1'b1, r, f, lat);
    checks++;
    if (r !== 16'hFFF2 || lat !== 1) begin
      failures++;
      $display("FAIL shr_signed out=%h lat=%0d required fff2/1", r, lat);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.i_a = 8'hA5; bus.i_b = 8'h0F; bus.i_fun = 4'd8; bus.i_signed = 1'b0; bus.i_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.o_out_valid !== 1'b1 || bus.o_alu_out !== 16'h00AA) begin
      failures++;
      $display("FAIL b2b_xor vld=%b out=%h required 1/00aa", bus.o_out_valid, bus.o_alu_out);
    end
    bus.i_a = 8'd5; bus.i_b = 8'd9; bus.i_fun = 4'd1;
    @(negedge clk);
    checks++;
    if (bus.o_out_valid !== 1'b1 || bus.o_alu_out !== 16'hFFFC || bus.o_flags[1] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_sub vld=%b out=%h c=%b required 1/fffc/1",
               bus.o_out_valid, bus.o_alu_out, bus.o_flags[1]);
    end
    bus.i_fun = 4'd15;
    @(negedge clk);
    bus.i_valid = 1'b0;
    checks++;
    if (bus.o_out_valid !== 1'b1 || bus.o_alu_out !== '0 || bus.o_flags !== 4'b0001) begin
      failures++;
      $display("FAIL b2b_op15 vld=%b out=%h flags=%b required 1/0000/0001",
               bus.o_out_valid, bus.o_alu_out, bus.o_flags);
    end
    @(negedge clk);
    checks++;
    if (bus.o_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end vld=%b required 0", bus.o_out_valid);
    end
  endtask

  task automatic test_reset_mid_div();
    logic [OW-1:0] r; logic [3:0] f; int lat;
    int seen = 0;
    @(negedge clk);
    bus.i_a = 8'd200; bus.i_b = 8'd7; bus.i_fun = 4'd3; bus.i_signed = 1'b0; bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.o_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_div_busy rdy=%b required 0", bus.o_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_alu_out !== '0 || bus.o_flags !== 4'h0 || bus.o_out_valid !== 1'b0 ||
        bus.o_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_div_reset out=%h flags=%h vld=%b rdy=%b required 0/0/0/1",
               bus.o_alu_out, bus.o_flags, bus.o_out_valid, bus.o_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2*W) begin
      @(negedge clk);
      if (bus.o_out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL mid_div_no_result pulses=%0d required 0", seen);
    end
    do_op(8'd3, 8'd4, 4'd0, 1'b0, r, f, lat);
    checks++;
    if (r !== 16'd7 || f !== 4'b0000 || lat !== 1) begin
      failures++;
      $display("FAIL post_reset_add out=%h flags=%b lat=%0d required 0007/0000/1", r, f, lat);
    end
  endtask

  task automatic test_random();
    logic [OW-1:0] r; logic [3:0] f; int lat;
    logic [W-1:0] a, b; logic [3:0] fun; bit sgn;
    int er, ef, el;
    for (int i = 0; i < 150; i++) begin
      a   = W'($urandom);
      b   = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
      fun = 4'($urandom);
      sgn = 1'($urandom);
      model(int'(a), int'(b), int'(fun), sgn, er, ef);
      el = (fun == 4'd2 || fun == 4'd3) ? W+1 : 1;
      do_op(a, b, fun, sgn, r, f, lat);
      checks++;
      if (r !== OW'(er) || f !== 4'(ef) || lat !== el) begin
        failures++;
        $display("FAIL rand op=%0d a=%h b=%h s=%0d out=%h flags=%b lat=%0d required %h/%b/%0d",
                 fun, a, b, sgn, r, f, lat, OW'(er), 4'(ef), el);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_div_hold();
    test_div_zero();
    test_mul_toggle();
    test_compare_shift();
    test_back_to_back();
    test_reset_mid_div();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU for the datapath's execute stage. It accepts one operation per valid/ready handshake and registers every result. Logic, add/sub, compare and shift operations finish in one cycle. MUL and DIV run iteratively over OPER_WIDTH cycles with backpressure. It adds status flags, signed compare/shift mode and variable shifts.

## Interface
- OPER_WIDTH, 8, operand width; must be ≥2 and a power of two.
- OUT_WIDTH, 2*OPER_WIDTH, result width.
- i_clk  in  1  clock; everything is on the rising edge.
- i_rst  in  1  reset. One clock; reset is asynchronous and active-low.
- i_a  in  OPER_WIDTH  operand A.
- i_b  in  OPER_WIDTH  operand B. For shifts, the shift amount is i_b mod OPER_WIDTH.
- i_fun  in  4  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 NAND, 7 NOR, 8 XOR, 9 XNOR, 10 EQL, 11 GRT, 12 LESS, 13 SHR, 14 SHL, 15 reserved.
- i_signed  in  1  two's-complement mode for GRT, LESS and SHR.
- i_valid  in  1  request valid.
- o_ready  out  1  block can accept a request.
- o_alu_out  out  OUT_WIDTH  registered result.
- o_flags  out  4  registered flags: [0] Z result==0, [1] C carry (ADD) / borrow (SUB), [2] V signed overflow (ADD/SUB), [3] DZ divide by zero.
- o_out_valid  out  1  one-cycle pulse marking a new o_alu_out/o_flags.

## Operation
- Accept: a request is taken on an edge where i_valid && o_ready. i_valid at any other time is ignored. i_a, i_b, i_fun and i_signed are captured at accept.
- FSM states:
  - IDLE: o_ready=1. An accepted MUL/DIV moves to BUSY with iteration counter=0. Any other accepted opcode writes its result at the same edge and stays in IDLE.
  - BUSY: o_ready=0. One iteration per edge. On the edge where counter==OPER_WIDTH-1, the result is written, o_out_valid is set, and the FSM returns to IDLE.
- Results:
  - Results narrower than OUT_WIDTH are zero-extended, except signed SHR, which is sign-extended.
  - ADD: a+b in OPER_WIDTH+1 bits, carry in bit OPER_WIDTH. C=carry. V=signed overflow of the OPER_WIDTH-bit sum.
  - SUB: ({0,a}-{0,b}) mod 2^OUT_WIDTH. C=1 iff a<b (unsigned). V=signed overflow of the OPER_WIDTH-bit difference.
  - MUL: unsigned shift-add; full OUT_WIDTH product.
  - DIV: unsigned restoring division. Quotient goes in o_alu_out[OPER_WIDTH-1:0], remainder in the upper half.
  - Divide by zero: b==0 runs the full latency and gives quotient all-ones, remainder=a, DZ=1.
  - Logic ops: bitwise on OPER_WIDTH bits.
  - EQL: result 1 if equal, else 0.
  - GRT: result 2 if a>b, else 0.
  - LESS: result 3 if a<b, else 0.
  - GRT and LESS compare signed when i_signed=1.
  - SHL: a<<sh, no bits lost inside OUT_WIDTH.
  - SHR: logical shift, or arithmetic when i_signed=1.
  - Opcode 15: result 0, Z=1, other flags 0, one-cycle path.
- Flags: C, V and DZ are 0 for every operation that does not define them. Z is always computed on the full OUT_WIDTH result.
- Between results, o_alu_out and o_flags hold their last value.

## Timing
- Reset values: o_alu_out=0, o_flags=0, o_out_valid=0, o_ready=1, FSM=IDLE, counter=0.
- Reset asserted mid-BUSY abandons the operation. No o_out_valid is produced for it.
- One-cycle ops, accepted at edge E:
  - o_out_valid=1 in the cycle after E.
  - Back-to-back accepts give one result per cycle.
- MUL/DIV, accepted at edge E:
  - o_ready=0 from after E through edge E+OPER_WIDTH.
  - o_out_valid=1 and o_ready=1 in the cycle after edge E+OPER_WIDTH.
  - Latency is OPER_WIDTH cycles. The next request can be accepted at edge E+OPER_WIDTH+1.
- o_out_valid never stays high two cycles for the same result.
- Operands changing while BUSY have no effect on the result in progress.

## Test plan
- Reset, then ADD a=200, b=100 with i_valid for one cycle:
  - next cycle o_alu_out=0x012C, C=1, V=0, Z=0, one o_out_valid pulse.
- DIV a=200, b=7 (OPER_WIDTH=8):
  - o_ready low for 8 cycles, then o_alu_out=0x041C, o_out_valid pulse.
  - i_valid held high throughout is not accepted until o_ready returns.
- DIV a=0x55, b=0:
  - after 8 cycles o_alu_out=0x55FF, DZ=1.
- MUL a=255, b=255:
  - o_alu_out=0xFE01 after 8 cycles.
  - operands toggled while BUSY do not change the result.
- GRT a=0x80, b=0x01 with i_signed=0 -> 2; then i_signed=1 -> 0.
- SHR a=0x90, b=3 with i_signed=1 -> 0xFFF2.
- Back-to-back XOR, SUB(5-9), opcode 15:
  - results 3 consecutive cycles: XOR value; SUB 0xFFFC with C=1; 0 with Z=1.
- Reset asserted mid-DIV:
  - all outputs return to reset values, no o_out_valid.
  - the next request then completes normally.
